// File: rtl/mips_defs_pkg.sv
// Shared MIPS encodings, the reset PC and the load-use hazard detector used
// around the pipeline stall registers.
package mips_defs;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
    localparam logic [31:0] NOP          = 32'h0000_0000;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2b;
    localparam logic [5:0] FN_SLL     = 6'h00;
    localparam logic [5:0] FN_ADDU    = 6'h21;
    localparam logic [5:0] FN_SUBU    = 6'h23;

    // A bubble decodes as OP_SPECIAL with rt=$0, so it never matches a producer.
    function automatic logic load_use_stall(input logic [31:0] ir_d, input logic [31:0] ir_e);
        logic [4:0] rt_e;
        logic       reads_rt;
        logic       hit;
        rt_e = ir_e[20:16];
        case (ir_d[31:26])
            OP_SPECIAL: reads_rt = 1'b1;
            OP_BEQ:     reads_rt = 1'b1;
            OP_BNE:     reads_rt = 1'b1;
            OP_SW:      reads_rt = 1'b1;
            default:    reads_rt = 1'b0;
        endcase
        if ((ir_e[31:26] == OP_LW) && (rt_e != 5'd0)) begin
            hit = (ir_d[25:21] == rt_e) || (reads_rt && (ir_d[20:16] == rt_e));
        end else begin
            hit = 1'b0;
        end
        return hit;
    endfunction

endpackage

// File: rtl/pipe_stall_regs_stage_reg.sv
// One pipeline latch: instruction plus its PC. clr turns the instruction into a
// bubble while the PC still follows its input.
module stage_reg
    import mips_defs::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        en,
    input  logic        clr,
    input  logic [31:0] ir_next,
    input  logic [31:0] pc_next,
    output logic [31:0] ir,
    output logic [31:0] pc
);

    logic [31:0] ir_r;
    logic [31:0] pc_r;

    // Stage latch: reset, bubble insert, load, or hold.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ir_r <= 32'h0000_0000;
            pc_r <= 32'h0000_0000;
        end else if (clr) begin
            ir_r <= NOP;
            pc_r <= pc_next;
        end else if (en) begin
            ir_r <= ir_next;
            pc_r <= pc_next;
        end else begin
            ir_r <= ir_r;
            pc_r <= pc_r;
        end
    end

    assign ir = ir_r;
    assign pc = pc_r;

endmodule

// File: rtl/pipe_stall_regs.sv
// Five-stage fetch/pipeline registers with load-use stall, bubble insertion,
// saturating stall statistics and a sticky deadlock diagnostic.
module pipe_stall_regs
    import mips_defs::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter int          MAX_STALL = 2,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             stop,
    input  logic [31:0]      NPC,
    input  logic [31:0]      IR_F,
    output logic [31:0]      PC,
    output logic [31:0]      IR_D,
    output logic [31:0]      IR_E,
    output logic [31:0]      IR_M,
    output logic [31:0]      IR_W,
    output logic [31:0]      PC_D,
    output logic [31:0]      PC_E,
    output logic [31:0]      PC_M,
    output logic [31:0]      PC_W,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             deadlock
);

    localparam int RUN_W = $clog2(MAX_STALL + 2);

    logic [31:0]      pc_r;
    logic [CNT_W-1:0] stall_cnt_r;
    logic [RUN_W-1:0] run_r;
    logic             deadlock_r;
    logic             advance_s;

    assign advance_s = ~stop;

    // Fetch address: holds while D is stalled.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc_r <= RESET_PC;
        end else if (advance_s) begin
            pc_r <= NPC;
        end else begin
            pc_r <= pc_r;
        end
    end

    stage_reg u_d (
        .clk(clk), .reset_n(reset_n), .en(advance_s), .clr(1'b0),
        .ir_next(IR_F), .pc_next(pc_r), .ir(IR_D), .pc(PC_D)
    );

    stage_reg u_e (
        .clk(clk), .reset_n(reset_n), .en(1'b1), .clr(stop),
        .ir_next(IR_D), .pc_next(PC_D), .ir(IR_E), .pc(PC_E)
    );

    stage_reg u_m (
        .clk(clk), .reset_n(reset_n), .en(1'b1), .clr(1'b0),
        .ir_next(IR_E), .pc_next(PC_E), .ir(IR_M), .pc(PC_M)
    );

    stage_reg u_w (
        .clk(clk), .reset_n(reset_n), .en(1'b1), .clr(1'b0),
        .ir_next(IR_M), .pc_next(PC_M), .ir(IR_W), .pc(PC_W)
    );

    // Total stall cycles, pinned at all-ones once reached.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (stop && (stall_cnt_r != {CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    // Consecutive-stall run length; deadlock latches when it passes MAX_STALL.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            run_r      <= {RUN_W{1'b0}};
            deadlock_r <= 1'b0;
        end else if (stop) begin
            if (run_r == RUN_W'(MAX_STALL)) begin
                run_r      <= run_r;
                deadlock_r <= 1'b1;
            end else begin
                run_r      <= run_r + {{(RUN_W-1){1'b0}}, 1'b1};
                deadlock_r <= deadlock_r;
            end
        end else begin
            run_r      <= {RUN_W{1'b0}};
            deadlock_r <= deadlock_r;
        end
    end

    assign PC        = pc_r;
    assign stall_cnt = stall_cnt_r;
    assign deadlock  = deadlock_r;

endmodule

// File: tb/tb_pipe_stall_regs.sv
// Bench for pipe_stall_regs: directed scenarios plus a randomized run against
// an array-based pipeline model.
module tb_pipe_stall_regs;

    localparam int          CNT_W     = 4;
    localparam int          MAX_STALL = 2;
    localparam logic [31:0] RST_PC    = 32'h0000_3000;
    localparam logic [31:0] LW1       = 32'h8C41_0000;  // lw   $1, 0($2)
    localparam logic [31:0] ADDU      = 32'h0021_1821;  // addu $3, $1, $1
    localparam logic [31:0] BEQ       = 32'h1020_0004;  // beq  $1, $0, +4

    logic             clk = 1'b0;
    logic             reset_n, stop;
    logic [31:0]      NPC, IR_F;
    logic [31:0]      PC, IR_D, IR_E, IR_M, IR_W, PC_D, PC_E, PC_M, PC_W;
    logic [CNT_W-1:0] stall_cnt;
    logic             deadlock;

    int n_vec = 0;
    int n_bad = 0;

    // model: index 0=D, 1=E, 2=M, 3=W
    logic [31:0] m_pc;
    logic [31:0] m_ir [4];
    logic [31:0] m_ps [4];
    int          m_cnt, m_run;
    logic        m_dl;

    always #5 clk = ~clk;

    pipe_stall_regs #(.RESET_PC(RST_PC), .MAX_STALL(MAX_STALL), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .stop(stop), .NPC(NPC), .IR_F(IR_F),
        .PC(PC), .IR_D(IR_D), .IR_E(IR_E), .IR_M(IR_M), .IR_W(IR_W),
        .PC_D(PC_D), .PC_E(PC_E), .PC_M(PC_M), .PC_W(PC_W),
        .stall_cnt(stall_cnt), .deadlock(deadlock)
    );

    task automatic tick(input logic rst_n, input logic st, input logic [31:0] npc, input logic [31:0] irf);
        reset_n = rst_n; stop = st; NPC = npc; IR_F = irf;
        @(posedge clk);
        if (!rst_n) begin
            m_pc = RST_PC;
            for (int i = 0; i < 4; i++) begin m_ir[i] = 32'h0; m_ps[i] = 32'h0; end
            m_cnt = 0; m_run = 0; m_dl = 1'b0;
        end else if (!st) begin
            for (int i = 3; i > 0; i--) begin m_ir[i] = m_ir[i-1]; m_ps[i] = m_ps[i-1]; end
            m_ir[0] = irf; m_ps[0] = m_pc; m_pc = npc; m_run = 0;
        end else begin
            for (int i = 3; i > 1; i--) begin m_ir[i] = m_ir[i-1]; m_ps[i] = m_ps[i-1]; end
            m_ir[1] = 32'h0; m_ps[1] = m_ps[0];
            m_cnt = (m_cnt + 1 > 15) ? 15 : m_cnt + 1;
            m_run = m_run + 1;
            if (m_run > MAX_STALL) m_dl = 1'b1;
        end
        #1;
    endtask

    task automatic run_free(input logic st, input logic [31:0] irf);
        tick(1'b1, st, m_pc + 32'd4, irf);
    endtask

    task automatic test_reset;
        tick(1'b0, 1'b1, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
        tick(1'b0, 1'b0, 32'h1234_5678, 32'hFFFF_FFFF);
        n_vec++; if (PC !== 32'h0000_3000) begin n_bad++; $display("FAIL reset_pc got %h want %h", PC, 32'h0000_3000); end
        n_vec++; if ({IR_D, IR_E, IR_M, IR_W} !== 128'h0) begin n_bad++; $display("FAIL reset_ir got %h %h %h %h want 0", IR_D, IR_E, IR_M, IR_W); end
        n_vec++; if ({PC_D, PC_E, PC_M, PC_W} !== 128'h0) begin n_bad++; $display("FAIL reset_pcs got %h %h %h %h want 0", PC_D, PC_E, PC_M, PC_W); end
        n_vec++; if ({stall_cnt, deadlock} !== 5'h0) begin n_bad++; $display("FAIL reset_cnt got %h/%b want 0/0", stall_cnt, deadlock); end
    endtask

    task automatic test_free_run;
        tick(1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 6; i++) run_free(1'b0, m_pc);
        n_vec++; if (IR_W !== 32'h0000_3008) begin n_bad++; $display("FAIL free_irw got %h want %h", IR_W, 32'h0000_3008); end
        n_vec++; if (PC !== 32'h0000_3018) begin n_bad++; $display("FAIL free_pc got %h want %h", PC, 32'h0000_3018); end
        n_vec++; if (PC_W !== 32'h0000_3008) begin n_bad++; $display("FAIL free_pcw got %h want %h", PC_W, 32'h0000_3008); end
    endtask

    task automatic test_load_use;
        tick(1'b0, 1'b0, 32'h0, 32'h0);
        run_free(1'b0, LW1);
        run_free(1'b0, ADDU);
        run_free(1'b1, 32'h1111_1111);
        n_vec++; if (IR_E !== 32'h0) begin n_bad++; $display("FAIL lu_bubble got %h want 0", IR_E); end
        n_vec++; if (IR_D !== ADDU) begin n_bad++; $display("FAIL lu_ird got %h want %h", IR_D, ADDU); end
        n_vec++; if (PC !== 32'h0000_3008) begin n_bad++; $display("FAIL lu_pc got %h want %h", PC, 32'h0000_3008); end
        n_vec++; if (PC_E !== 32'h0000_3004) begin n_bad++; $display("FAIL lu_pce got %h want %h", PC_E, 32'h0000_3004); end
        n_vec++; if (IR_M !== LW1) begin n_bad++; $display("FAIL lu_irm got %h want %h", IR_M, LW1); end
        n_vec++; if (stall_cnt !== 4'd1) begin n_bad++; $display("FAIL lu_cnt got %h want 1", stall_cnt); end
        run_free(1'b0, 32'h2222_2222);
        n_vec++; if (IR_E !== ADDU) begin n_bad++; $display("FAIL lu_adv got %h want %h", IR_E, ADDU); end
        n_vec++; if (IR_M !== 32'h0) begin n_bad++; $display("FAIL lu_bubm got %h want 0", IR_M); end
    endtask

    task automatic test_beq_two_bubbles;
        tick(1'b0, 1'b0, 32'h0, 32'h0);
        run_free(1'b0, LW1);
        run_free(1'b0, BEQ);
        run_free(1'b1, 32'h0);
        run_free(1'b1, 32'h0);
        n_vec++; if ({IR_E, IR_M, IR_W} !== {32'h0, 32'h0, LW1}) begin n_bad++; $display("FAIL beq_s2 got %h %h %h want 0 0 %h", IR_E, IR_M, IR_W, LW1); end
        run_free(1'b0, 32'h0);
        n_vec++; if ({IR_E, IR_M, IR_W} !== {BEQ, 32'h0, 32'h0}) begin n_bad++; $display("FAIL beq_r1 got %h %h %h want %h 0 0", IR_E, IR_M, IR_W, BEQ); end
        run_free(1'b0, 32'h0);
        n_vec++; if ({IR_M, IR_W} !== {BEQ, 32'h0}) begin n_bad++; $display("FAIL beq_r2 got %h %h want %h 0", IR_M, IR_W, BEQ); end
        run_free(1'b0, 32'h0);
        n_vec++; if (IR_W !== BEQ) begin n_bad++; $display("FAIL beq_r3 got %h want %h", IR_W, BEQ); end
        n_vec++; if (deadlock !== 1'b0) begin n_bad++; $display("FAIL beq_dl got %b want 0", deadlock); end
    endtask

    task automatic test_deadlock;
        tick(1'b0, 1'b0, 32'h0, 32'h0);
        run_free(1'b1, 32'h0);
        run_free(1'b1, 32'h0);
        n_vec++; if (deadlock !== 1'b0) begin n_bad++; $display("FAIL dl_early got %b want 0", deadlock); end
        run_free(1'b1, 32'h0);
        n_vec++; if (deadlock !== 1'b1) begin n_bad++; $display("FAIL dl_set got %b want 1", deadlock); end
        run_free(1'b0, 32'h5);
        run_free(1'b0, 32'h6);
        n_vec++; if (deadlock !== 1'b1) begin n_bad++; $display("FAIL dl_sticky got %b want 1", deadlock); end
        n_vec++; if (IR_E !== 32'h5) begin n_bad++; $display("FAIL dl_pipe got %h want 5", IR_E); end
    endtask

    task automatic test_alternate;
        tick(1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 20; i++) run_free(i[0], 32'h0);
        n_vec++; if (deadlock !== 1'b0) begin n_bad++; $display("FAIL alt_dl got %b want 0", deadlock); end
        n_vec++; if (stall_cnt !== 4'hA) begin n_bad++; $display("FAIL alt_cnt got %h want a", stall_cnt); end
    endtask

    task automatic test_saturation;
        tick(1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 14; i++) run_free(1'b1, 32'h0);
        n_vec++; if (stall_cnt !== 4'hE) begin n_bad++; $display("FAIL sat_14 got %h want e", stall_cnt); end
        for (int i = 0; i < 6; i++) run_free(1'b1, 32'h0);
        n_vec++; if (stall_cnt !== 4'hF) begin n_bad++; $display("FAIL sat_20 got %h want f", stall_cnt); end
    endtask

    task automatic test_reset_mid_stall;
        tick(1'b0, 1'b0, 32'h0, 32'h0);
        run_free(1'b0, LW1);
        run_free(1'b0, ADDU);
        run_free(1'b1, 32'h0);
        tick(1'b0, 1'b1, 32'hABCD_0000, 32'h7777_7777);
        n_vec++; if (PC !== 32'h0000_3000) begin n_bad++; $display("FAIL rms_pc got %h want %h", PC, 32'h0000_3000); end
        n_vec++; if ({IR_D, IR_E, IR_M, IR_W, PC_D, PC_E, PC_M, PC_W} !== 256'h0) begin n_bad++; $display("FAIL rms_stages got %h %h %h %h want 0", IR_D, IR_E, IR_M, IR_W); end
        n_vec++; if ({stall_cnt, deadlock} !== 5'h0) begin n_bad++; $display("FAIL rms_cnt got %h/%b want 0/0", stall_cnt, deadlock); end
        tick(1'b1, 1'b0, 32'h0000_3004, 32'h4444_4444);
        n_vec++; if ({IR_D, PC_D, PC} !== {32'h4444_4444, 32'h0000_3000, 32'h0000_3004}) begin n_bad++; $display("FAIL rms_after got %h %h %h want 44444444 3000 3004", IR_D, PC_D, PC); end
    endtask

    task automatic test_random;
        tick(1'b0, 1'b0, 32'h0, 32'h0);
        for (int c = 0; c < 400; c++) begin
            tick(($urandom_range(0, 59) != 0), ($urandom_range(0, 2) == 0), $urandom, $urandom);
            n_vec++; if (PC !== m_pc) begin n_bad++; $display("FAIL rnd_pc c=%0d got %h want %h", c, PC, m_pc); end
            n_vec++; if ({IR_D, IR_E, IR_M, IR_W} !== {m_ir[0], m_ir[1], m_ir[2], m_ir[3]}) begin
                n_bad++; $display("FAIL rnd_ir c=%0d got %h %h %h %h want %h %h %h %h", c, IR_D, IR_E, IR_M, IR_W, m_ir[0], m_ir[1], m_ir[2], m_ir[3]);
            end
            n_vec++; if ({PC_D, PC_E, PC_M, PC_W} !== {m_ps[0], m_ps[1], m_ps[2], m_ps[3]}) begin
                n_bad++; $display("FAIL rnd_pcs c=%0d got %h %h %h %h want %h %h %h %h", c, PC_D, PC_E, PC_M, PC_W, m_ps[0], m_ps[1], m_ps[2], m_ps[3]);
            end
            n_vec++; if (stall_cnt !== CNT_W'(m_cnt)) begin n_bad++; $display("FAIL rnd_cnt c=%0d got %h want %h", c, stall_cnt, CNT_W'(m_cnt)); end
            n_vec++; if (deadlock !== m_dl) begin n_bad++; $display("FAIL rnd_dl c=%0d got %b want %b", c, deadlock, m_dl); end
        end
    endtask

    initial begin
        reset_n = 1'b0; stop = 1'b0; NPC = 32'h0; IR_F = 32'h0;
        test_reset;
        test_free_run;
        test_load_use;
        test_beq_two_bubbles;
        test_deadlock;
        test_alternate;
        test_saturation;
        test_reset_mid_stall;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
